// File: rtl/serial_to_parallel_8.sv
`default_nettype none
// serial_to_parallel_8: one bit per cycle under valid/ready, eight bits assembled into a
// separately handshaked output byte so the next byte can be collected meanwhile.  Rev 1.0
module serial_to_parallel_8 #(
  parameter int LSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       restart,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       in_ready,
  output logic [2:0] bit_index,
  output logic [7:0] output_lines,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam logic [2:0] LAST_BIT = 3'd7;

  logic [7:0] col, col_next;
  logic [2:0] cnt, cnt_next;
  logic [7:0] out_reg, out_next;
  logic       ov, ov_next;
  logic [2:0] pos;
  logic       accept;
  logic       pop;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      col     <= 8'h00;
      cnt     <= 3'd0;
      out_reg <= 8'h00;
      ov      <= 1'b0;
    end else begin
      col     <= col_next;
      cnt     <= cnt_next;
      out_reg <= out_next;
      ov      <= ov_next;
    end
  end

  // Next state: completion is applied after pop so a simultaneous pop never leaves a bubble
  always_comb begin
    pos      = (LSB_FIRST != 0) ? cnt : (LAST_BIT - cnt);
    accept   = in_valid && in_ready && !restart;
    pop      = ov && out_ready;
    col_next = col;
    cnt_next = cnt;
    out_next = out_reg;
    ov_next  = ov;
    if (pop) begin
      ov_next = 1'b0;
    end
    if (restart) begin
      col_next = 8'h00;
      cnt_next = 3'd0;
    end else if (accept) begin
      col_next[pos] = in_bit;
      cnt_next      = cnt + 3'd1;
      if (cnt == LAST_BIT) begin
        out_next = col_next;
        ov_next  = 1'b1;
        col_next = 8'h00;
      end
    end
  end

  // Outputs: only the 8th bit stalls, and only while it would overwrite an untaken byte
  always_comb begin
    in_ready     = !((cnt == LAST_BIT) && ov && !out_ready);
    bit_index    = cnt;
    output_lines = out_reg;
    out_valid    = ov;
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_to_parallel_8.sv
`default_nettype none
// tb_serial_to_parallel_8: directed scenarios with a byte scoreboard checked at every pop.
module tb_serial_to_parallel_8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       restart = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, in_ready_m;
  logic [2:0] bit_index, bit_index_m;
  logic [7:0] output_lines, output_lines_m;
  logic       out_valid, out_valid_m;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] q_lsb[$];
  logic [7:0] q_msb[$];
  logic [7:0] m_byte = 8'h00;
  int         m_n = 0;

  serial_to_parallel_8 #(.LSB_FIRST(1)) dut_lsb (
    .clk(clk), .reset(reset), .restart(restart), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready), .bit_index(bit_index), .output_lines(output_lines),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  serial_to_parallel_8 #(.LSB_FIRST(0)) dut_msb (
    .clk(clk), .reset(reset), .restart(restart), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready_m), .bit_index(bit_index_m), .output_lines(output_lines_m),
    .out_valid(out_valid_m), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Stream-position model: bit k of the stream is bit k of the LSB-first byte.
  task automatic model_accept(input logic b);
    m_byte[m_n] = b;
    m_n++;
    if (m_n == 8) begin
      q_lsb.push_back(m_byte);
      q_msb.push_back(rev8(m_byte));
      m_byte = 8'h00;
      m_n = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop monitor: out_ready is stable from here to the next rising edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      n_vec++;
      if (q_lsb.size() == 0) begin
        n_err++;
        $display("FAIL pop_lsb: unexpected byte %h, no byte expected", output_lines);
      end else begin
        logic [7:0] e;
        e = q_lsb.pop_front();
        if (output_lines !== e) begin
          n_err++;
          $display("FAIL pop_lsb: got %h expected %h", output_lines, e);
        end
      end
    end
    if (!reset && out_valid_m && out_ready) begin
      n_vec++;
      if (q_msb.size() == 0) begin
        n_err++;
        $display("FAIL pop_msb: unexpected byte %h, no byte expected", output_lines_m);
      end else begin
        logic [7:0] e;
        e = q_msb.pop_front();
        if (output_lines_m !== e) begin
          n_err++;
          $display("FAIL pop_msb: got %h expected %h", output_lines_m, e);
        end
      end
    end
  end

  // Offer one bit, waiting (bounded) for in_ready, and leave in_valid high afterwards.
  task automatic send_bit(input logic b);
    int k;
    in_valid = 1'b1;
    in_bit   = b;
    #1;
    k = 0;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
    model_accept(b);
    tick();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic flush_model();
    q_lsb.delete();
    q_msb.delete();
    m_byte = 8'h00;
    m_n = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    flush_model();
    n_vec++;
    if ({out_valid, output_lines, bit_index, in_ready} !== {1'b0, 8'h00, 3'd0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_state: ov=%b out=%h idx=%0d rdy=%b required 0 00 0 1",
               out_valid, output_lines, bit_index, in_ready);
    end
    n_vec++;
    if ({out_valid_m, output_lines_m, bit_index_m, in_ready_m} !== {1'b0, 8'h00, 3'd0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_state_msb: ov=%b out=%h idx=%0d rdy=%b required 0 00 0 1",
               out_valid_m, output_lines_m, bit_index_m, in_ready_m);
    end
  endtask

  task automatic test_lsb_byte();
    logic [7:0] v;
    int hi_cycles;
    v = 8'h03;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (bit_index !== 3'(i)) begin
        n_err++;
        $display("FAIL lsb_index: got %0d expected %0d", bit_index, i);
      end
      send_bit(v[i]);
    end
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || output_lines !== 8'h03 || bit_index !== 3'd0) begin
      n_err++;
      $display("FAIL lsb_byte: ov=%b out=%h idx=%0d required 1 03 0", out_valid, output_lines, bit_index);
    end
    hi_cycles = 1;
    repeat (3) begin
      tick();
      if (out_valid) hi_cycles++;
    end
    n_vec++;
    if (hi_cycles != 1) begin
      n_err++;
      $display("FAIL lsb_valid_width: %0d cycles high, required 1", hi_cycles);
    end
  endtask

  task automatic test_msb_byte();
    out_ready = 1'b1;
    send_byte(8'h03);
    in_valid = 1'b0;
    n_vec++;
    if (out_valid_m !== 1'b1 || output_lines_m !== 8'hC0 || bit_index_m !== 3'd0) begin
      n_err++;
      $display("FAIL msb_byte: ov=%b out=%h idx=%0d required 1 c0 0", out_valid_m, output_lines_m, bit_index_m);
    end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_byte(8'h03);
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || output_lines !== 8'h03) begin
      n_err++;
      $display("FAIL bp_stall: rdy=%b ov=%b out=%h required 0 1 03", in_ready, out_valid, output_lines);
    end
    tick();
    n_vec++;
    if (in_ready !== 1'b0 || bit_index !== 3'd7 || output_lines !== 8'h03) begin
      n_err++;
      $display("FAIL bp_hold: rdy=%b idx=%0d out=%h required 0 7 03", in_ready, bit_index, output_lines);
    end
    out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: in_ready=%b required 1", in_ready);
    end
    model_accept(1'b1);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || output_lines !== 8'hFF || bit_index !== 3'd0) begin
      n_err++;
      $display("FAIL bp_second: ov=%b out=%h idx=%0d required 1 ff 0", out_valid, output_lines, bit_index);
    end
    tick();
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_restart();
    out_ready = 1'b1;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    restart  = 1'b1;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    m_byte   = 8'h00;
    m_n      = 0;
    tick();
    restart = 1'b0;
    n_vec++;
    if (bit_index !== 3'd0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL restart_index: idx=%0d ov=%b required 0 0", bit_index, out_valid);
    end
    send_byte(8'h81);
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || output_lines !== 8'h81) begin
      n_err++;
      $display("FAIL restart_byte: ov=%b out=%h required 1 81", out_valid, output_lines);
    end
    tick();
  endtask

  task automatic test_pop_and_complete();
    out_ready = 1'b0;
    send_byte(8'h03);
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    in_valid  = 1'b1;
    in_bit    = 1'b1;
    out_ready = 1'b1;
    #1;
    model_accept(1'b1);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || output_lines !== 8'hFF) begin
      n_err++;
      $display("FAIL pop_complete: ov=%b out=%h required 1 ff", out_valid, output_lines);
    end
    n_vec++;
    if (output_lines_m !== 8'hFF || out_valid_m !== 1'b1) begin
      n_err++;
      $display("FAIL pop_complete_msb: ov=%b out=%h required 1 ff", out_valid_m, output_lines_m);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || bit_index !== 3'd4 || output_lines !== 8'hA5) begin
      n_err++;
      $display("FAIL reset_mid_setup: ov=%b idx=%0d out=%h required 1 4 a5", out_valid, bit_index, output_lines);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    flush_model();
    n_vec++;
    if ({out_valid, output_lines, bit_index, in_ready} !== {1'b0, 8'h00, 3'd0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_mid: ov=%b out=%h idx=%0d rdy=%b required 0 00 0 1",
               out_valid, output_lines, bit_index, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_lsb_byte();
    test_msb_byte();
    test_backpressure();
    test_restart();
    test_pop_and_complete();
    test_reset_mid();
    out_ready = 1'b1;
    send_byte(8'h5A);
    in_valid = 1'b0;
    repeat (3) tick();
    n_vec++;
    if (q_lsb.size() != 0 || q_msb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d/%0d bytes never popped, required 0", q_lsb.size(), q_msb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
